sram_wb_bridge: RTL and testbench

// Wishbone B4 classic slave that fronts the 512x32 single-port management SRAM (RW port 0).

---
 rtl/mgmt_mem_pkg.sv | 15 +
 rtl/sram_wb_bridge_if.sv | 27 ++
 rtl/sram_wb_bridge.sv | 80 ++++++++
 tb/tb_sram_wb_bridge.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/mgmt_mem_pkg.sv
// Shared constants for the management SRAM and its Wishbone bridge.
// Holds the SRAM geometry and the bridge FSM state encoding.
package mgmt_mem_pkg;

    localparam int ADDR_WIDTH = 9;
    localparam int DATA_WIDTH = 32;
    localparam int NUM_WMASKS = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        ACK     = 2'd2
    } state_t;

endpackage

// File: rtl/sram_wb_bridge_if.sv
// Wishbone B4 classic bus bundle between a master and the SRAM bridge.
// The slave modport is the bridge side and the master modport is the initiator side.
interface sram_wb_bridge_if #(
    parameter int DATA_WIDTH = mgmt_mem_pkg::DATA_WIDTH,
    parameter int NUM_WMASKS = mgmt_mem_pkg::NUM_WMASKS
);

    logic                  wbs_cyc_i;
    logic                  wbs_stb_i;
    logic                  wbs_we_i;
    logic [NUM_WMASKS-1:0] wbs_sel_i;
    logic [31:0]           wbs_adr_i;
    logic [DATA_WIDTH-1:0] wbs_dat_i;
    logic                  wbs_ack_o;
    logic [DATA_WIDTH-1:0] wbs_dat_o;

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

endinterface

// File: rtl/sram_wb_bridge.sv
// Wishbone classic slave in front of the single-port management SRAM.
// Decodes the address window, drives the SRAM port directly from the bus and sequences read latency.
module sram_wb_bridge #(
    parameter int          ADDR_WIDTH = mgmt_mem_pkg::ADDR_WIDTH,
    parameter int          DATA_WIDTH = mgmt_mem_pkg::DATA_WIDTH,
    parameter int          NUM_WMASKS = mgmt_mem_pkg::NUM_WMASKS,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    sram_wb_bridge_if.slave       wb,
    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [NUM_WMASKS-1:0] sram_wmask0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    input  logic [DATA_WIDTH-1:0] sram_dout0
);

    import mgmt_mem_pkg::*;

    localparam int TAG_LSB = ADDR_WIDTH + 2;

    state_t                state;
    logic                  ack_q;
    logic [DATA_WIDTH-1:0] dat_q;
    logic                  hit;
    logic                  access;
    logic                  unused_adr;

    assign hit = wb.wbs_cyc_i & wb.wbs_stb_i &
                 (wb.wbs_adr_i[31:TAG_LSB] == BASE_ADDR[31:TAG_LSB]);

    // A write with no byte selects is acked but never touches the SRAM.
    assign access = hit & (state == IDLE) & ~wb_rst_i &
                    (~wb.wbs_we_i | (|wb.wbs_sel_i));

    assign sram_csb0   = ~access;
    assign sram_web0   = ~(access & wb.wbs_we_i);
    assign sram_wmask0 = wb.wbs_sel_i;
    assign sram_addr0  = wb.wbs_adr_i[ADDR_WIDTH+1:2];
    assign sram_din0   = wb.wbs_dat_i;

    assign wb.wbs_ack_o = ack_q;
    assign wb.wbs_dat_o = dat_q;
    assign unused_adr   = ^wb.wbs_adr_i[1:0];

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state <= IDLE;
            ack_q <= 1'b0;
            dat_q <= '0;
        end else begin
            ack_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (hit && wb.wbs_we_i) begin
                        state <= ACK;
                        ack_q <= 1'b1;
                    end else if (hit) begin
                        state <= RD_WAIT;
                    end
                end
                // SRAM output is valid now; a master that gave up gets no ack.
                RD_WAIT: begin
                    if (wb.wbs_cyc_i && wb.wbs_stb_i) begin
                        dat_q <= sram_dout0;
                        state <= ACK;
                        ack_q <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                ACK:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_wb_bridge.sv
// Bench for sram_wb_bridge: bridge plus a behavioural SRAM, checked against a byte-level memory model.
// Directed scenarios first, then a randomized mix of reads, writes and out-of-window accesses.
module tb_sram_wb_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        csb0;
    logic        web0;
    logic [3:0]  wmask0;
    logic [8:0]  addr0;
    logic [31:0] din0;
    logic [31:0] dout0 = 32'h0;

    logic [31:0] sramMem  [512]  = '{default: 32'h0};
    logic [7:0]  refBytes [2048] = '{default: 8'h0};
    logic [31:0] lastRead = 32'h0;

    int checkCount = 0;
    int errorCount = 0;

    sram_wb_bridge_if wb ();

    sram_wb_bridge #(.BASE_ADDR(32'h0000_0000)) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .wb          (wb),
        .sram_csb0   (csb0),
        .sram_web0   (web0),
        .sram_wmask0 (wmask0),
        .sram_addr0  (addr0),
        .sram_din0   (din0),
        .sram_dout0  (dout0)
    );

    always #5 clk = ~clk;

    // Behavioural single-port SRAM with one-cycle read latency.
    always @(posedge clk) begin
        if (!csb0) begin
            if (!web0) begin
                for (int i = 0; i < 4; i++)
                    if (wmask0[i]) sramMem[addr0][8*i +: 8] <= din0[8*i +: 8];
            end else begin
                dout0 <= sramMem[addr0];
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, observed, expected);
        end
    endtask

    function automatic int unsigned wordOf(input logic [31:0] adr);
        return (adr / 4) % 512;
    endfunction

    function automatic logic [31:0] refRead(input logic [31:0] adr);
        int unsigned b = wordOf(adr) * 4;
        return {refBytes[b+3], refBytes[b+2], refBytes[b+1], refBytes[b]};
    endfunction

    task automatic refWrite(input logic [31:0] adr, input logic [31:0] data, input logic [3:0] sel);
        int unsigned b = wordOf(adr) * 4;
        for (int i = 0; i < 4; i++)
            if (sel[i]) refBytes[b+i] = data[8*i +: 8];
    endtask

    task automatic applyStimulus(input logic cyc, input logic stb, input logic we,
                                 input logic [31:0] adr, input logic [31:0] data,
                                 input logic [3:0] sel);
        wb.wbs_cyc_i = cyc;
        wb.wbs_stb_i = stb;
        wb.wbs_we_i  = we;
        wb.wbs_adr_i = adr;
        wb.wbs_dat_i = data;
        wb.wbs_sel_i = sel;
    endtask

    task automatic idleBus();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    // Request held into the ack cycle to confirm the ACK state blocks a second access.
    task automatic wbWrite(input logic [31:0] adr, input logic [31:0] data, input logic [3:0] sel);
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, 1'b1, adr, data, sel);
        #1;
        checkOutput("wr_csb", {31'h0, csb0}, (sel != 4'h0) ? 32'h0 : 32'h1);
        if (sel != 4'h0) checkOutput("wr_web", {31'h0, web0}, 32'h0);
        checkOutput("wr_addr", {23'h0, addr0}, wordOf(adr));
        checkOutput("wr_mask", {28'h0, wmask0}, {28'h0, sel});
        checkOutput("wr_din", din0, data);
        checkOutput("wr_ack_early", {31'h0, wb.wbs_ack_o}, 32'h0);
        @(negedge clk);
        checkOutput("wr_ack", {31'h0, wb.wbs_ack_o}, 32'h1);
        checkOutput("wr_ack_csb", {31'h0, csb0}, 32'h1);
        checkOutput("wr_dato_hold", wb.wbs_dat_o, lastRead);
        refWrite(adr, data, sel);
        idleBus();
    endtask

    task automatic wbRead(input logic [31:0] adr);
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, 1'b0, adr, $urandom, 4'($urandom));
        #1;
        checkOutput("rd_csb", {31'h0, csb0}, 32'h0);
        checkOutput("rd_web", {31'h0, web0}, 32'h1);
        checkOutput("rd_addr", {23'h0, addr0}, wordOf(adr));
        checkOutput("rd_ack_early", {31'h0, wb.wbs_ack_o}, 32'h0);
        @(negedge clk);
        checkOutput("rd_wait_ack", {31'h0, wb.wbs_ack_o}, 32'h0);
        checkOutput("rd_wait_csb", {31'h0, csb0}, 32'h1);
        @(negedge clk);
        lastRead = refRead(adr);
        checkOutput("rd_ack", {31'h0, wb.wbs_ack_o}, 32'h1);
        checkOutput("rd_data", wb.wbs_dat_o, lastRead);
        checkOutput("rd_ack_csb", {31'h0, csb0}, 32'h1);
        idleBus();
    endtask

    task automatic missAccess(input logic [31:0] adr, input logic we, input int cycles);
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, we, adr, $urandom, 4'hF);
        for (int i = 0; i < cycles; i++) begin
            #1;
            checkOutput("miss_csb", {31'h0, csb0}, 32'h1);
            checkOutput("miss_ack", {31'h0, wb.wbs_ack_o}, 32'h0);
            @(negedge clk);
        end
        idleBus();
    endtask

    initial begin
        logic [31:0] adr;
        logic [31:0] data;
        int          pick;

        // A hit is presented while reset is held: the SRAM must stay deselected.
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h4, 32'h1234_5678, 4'hF);
        repeat (3) @(negedge clk);
        checkOutput("rst_csb", {31'h0, csb0}, 32'h1);
        checkOutput("rst_web", {31'h0, web0}, 32'h1);
        checkOutput("rst_ack", {31'h0, wb.wbs_ack_o}, 32'h0);
        checkOutput("rst_dato", wb.wbs_dat_o, 32'h0);
        rst = 1'b0;
        idleBus();

        wbWrite(32'h004, 32'hDEAD_BEEF, 4'hF);
        wbRead(32'h004);
        checkOutput("deadbeef", lastRead, 32'hDEAD_BEEF);

        wbWrite(32'h008, 32'hFFFF_FFFF, 4'hF);
        wbWrite(32'h008, 32'h1122_3344, 4'b0101);
        wbRead(32'h008);
        checkOutput("bytemask", lastRead, 32'hFF22_FF44);

        missAccess(32'h800, 1'b0, 10);
        missAccess(32'h0001_0004, 1'b1, 4);
        wbWrite(32'h7FC, 32'hA5A5_0F0F, 4'hF);
        wbRead(32'h7FD);

        // Abort a read in RD_WAIT by dropping cyc; no ack and no capture.
        wbWrite(32'h00C, 32'h0BAD_F00D, 4'hF);
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h00C, 32'h0, 4'hF);
        @(negedge clk);
        wb.wbs_cyc_i = 1'b0;
        checkOutput("abort_ack0", {31'h0, wb.wbs_ack_o}, 32'h0);
        @(negedge clk);
        checkOutput("abort_ack1", {31'h0, wb.wbs_ack_o}, 32'h0);
        checkOutput("abort_dato", wb.wbs_dat_o, lastRead);
        idleBus();
        @(negedge clk);
        checkOutput("abort_ack2", {31'h0, wb.wbs_ack_o}, 32'h0);
        wbRead(32'h000);

        // Reset pulsed during the ack of a write, with the request still asserted.
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h020, 32'hCAFE_1234, 4'hF);
        @(negedge clk);
        checkOutput("rstack_ack", {31'h0, wb.wbs_ack_o}, 32'h1);
        refWrite(32'h020, 32'hCAFE_1234, 4'hF);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rstack_ack0", {31'h0, wb.wbs_ack_o}, 32'h0);
        checkOutput("rstack_csb", {31'h0, csb0}, 32'h1);
        rst = 1'b0;
        idleBus();
        lastRead = 32'h0;
        checkOutput("rstack_dato", wb.wbs_dat_o, 32'h0);
        wbRead(32'h020);

        wbWrite(32'h010, 32'h5555_AAAA, 4'hF);
        wbWrite(32'h010, 32'h9999_9999, 4'h0);
        wbRead(32'h010);
        checkOutput("sel0_keep", lastRead, 32'h5555_AAAA);

        for (int n = 0; n < 120; n++) begin
            pick = $urandom_range(0, 9);
            adr  = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 15) * 4 : $urandom_range(0, 511) * 4;
            adr  = adr + $urandom_range(0, 3);
            data = $urandom;
            if (pick == 0) begin
                adr = $urandom;
                if (adr[31:11] == 21'h0) adr[31] = 1'b1;
                missAccess(adr, 1'($urandom), 3);
            end else if (pick < 5) begin
                wbWrite(adr, data, 4'($urandom));
            end else begin
                wbRead(adr);
            end
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, errorCount);
        $finish;
    end

endmodule
